// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the sequenced shift/rotate unit of the 5-bit ALU.
package alu_seq_pkg;

  localparam int WIDTH = 5;

  typedef enum logic [1:0] {OP_ROR, OP_ROL, OP_SHR, OP_SHL} op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Rotates repeat every WIDTH steps, while shifts saturate once every bit has left.
  function automatic logic [2:0] eff_count(op_t op, logic [4:0] b);
    if (op == OP_ROR || op == OP_ROL)
      return 3'(b % 5'd5);
    else
      return (b > 5'd5) ? 3'd5 : 3'(b);
  endfunction

endpackage

// File: rtl/alu_step_unit.sv
// Single-bit shift/rotate step: produces the next operand value and the bit pushed out.
module alu_step_unit
  import alu_seq_pkg::*;
(
  input  op_t              op,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_next,
  output logic             out_bit
);

  always_comb begin
    r_next  = r;
    out_bit = 1'b0;
    case (op)
      OP_ROR: begin
        r_next  = {r[0], r[4:1]};
        out_bit = r[0];
      end
      OP_ROL: begin
        r_next  = {r[3:0], r[4]};
        out_bit = r[4];
      end
      OP_SHR: begin
        r_next  = {1'b0, r[4:1]};
        out_bit = r[0];
      end
      OP_SHL: begin
        r_next  = {r[3:0], 1'b0};
        out_bit = r[4];
      end
      default: begin
        r_next  = r;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift/rotate controller: one request at a time, one bit step per clock.
module alu_shift_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_zero,
  output logic             out_carry,
  output logic             busy
);

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] r;
  logic             carry;
  logic [2:0]       cnt;
  logic [2:0]       n_acc;
  logic [WIDTH-1:0] step_r;
  logic             step_bit;

  assign n_acc = eff_count(op_t'(in_op), in_b);

  alu_step_unit u_step (
    .op      (op),
    .r       (r),
    .r_next  (step_r),
    .out_bit (step_bit)
  );

  // Handshake flags are registered alongside the state so they change only on clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op        <= OP_ROR;
      r         <= '0;
      carry     <= 1'b0;
      cnt       <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            r        <= in_a;
            op       <= op_t'(in_op);
            cnt      <= n_acc;
            carry    <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (n_acc == 3'd0) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r     <= step_r;
          carry <= step_bit;
          cnt   <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_r     = r;
  assign out_zero  = (r == '0);
  assign out_carry = carry;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a cycle-level result/handshake model.
module tb_alu_shift_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] in_op = 2'd0;
  logic [4:0] in_a = 5'd0;
  logic [4:0] in_b = 5'd0;
  logic       in_ready, out_valid, out_zero, out_carry, busy;
  logic [4:0] out_r;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_shift_sequencer #(.WIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_zero  (out_zero),
    .out_carry (out_carry),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Closed-form result: whole-amount rotate/shift, carry is the last bit to leave the operand.
  function automatic void modelCalc(input int op, input int a, input int b,
                                    output int n, output int res, output int c);
    n = (op < 2) ? (b % 5) : ((b > 5) ? 5 : b);
    res = 0;
    c = 0;
    case (op)
      0: begin res = ((a >> n) | (a << (5 - n))) & 31; c = (n == 0) ? 0 : (a >> (n - 1)) & 1; end
      1: begin res = ((a << n) | (a >> (5 - n))) & 31; c = (n == 0) ? 0 : (a >> (5 - n)) & 1; end
      2: begin res = a >> n;                            c = (n == 0) ? 0 : (a >> (n - 1)) & 1; end
      default: begin res = (a << n) & 31;               c = (n == 0) ? 0 : (a >> (5 - n)) & 1; end
    endcase
  endfunction

  int cyc = 0;
  int doneAt = 0;
  int mN = 0;
  int mR = 0;
  int mC = 0;
  bit mIdle = 1'b1;
  bit mValid = 1'b0;
  bit checkOn = 1'b0;

  // Model: a request accepted on edge k has its result visible from edge k+N until out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mIdle = 1'b1;
      mValid = 1'b0;
      mR = 0;
      mC = 0;
      cyc = 0;
    end else begin
      cyc++;
      if (mIdle) begin
        if (in_valid) begin
          modelCalc(int'(in_op), int'(in_a), int'(in_b), mN, mR, mC);
          mIdle = 1'b0;
          doneAt = cyc + mN;
          if (mN == 0) mValid = 1'b1;
        end
      end else if (!mValid) begin
        if (cyc == doneAt) mValid = 1'b1;
      end else if (out_ready) begin
        mValid = 1'b0;
        mIdle = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && checkOn) begin
      checkOutput("cmp_in_ready", int'(in_ready), int'(mIdle));
      checkOutput("cmp_out_valid", int'(out_valid), int'(mValid));
      checkOutput("cmp_busy", int'(busy), int'(!mIdle));
      if (mValid) begin
        checkOutput("cmp_out_r", int'(out_r), mR);
        checkOutput("cmp_out_carry", int'(out_carry), mC);
        checkOutput("cmp_out_zero", int'(out_zero), (mR == 0) ? 1 : 0);
      end
    end
  end

  task automatic waitReady(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput(name, int'(got), 1);
  endtask

  task automatic applyStimulus(input int op, input int a, input int b, input int expR,
                               input int expC, input int expLat, input int holdCycles);
    int lat;
    bit got;
    @(negedge clk);
    waitReady("ready_wait");
    in_valid = 1'b1;
    in_op = 2'(op);
    in_a = 5'(a);
    in_b = 5'(b);
    @(negedge clk);
    in_valid = 1'b0;
    in_op = 2'(op ^ 1);
    in_a = 5'(~a);
    in_b = 5'(b + 1);
    lat = 1;
    got = out_valid;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = out_valid;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("result_r", int'(out_r), expR);
    checkOutput("result_carry", int'(out_carry), expC);
    checkOutput("result_zero", int'(out_zero), (expR == 0) ? 1 : 0);
    repeat (holdCycles) begin
      @(negedge clk);
      checkOutput("hold_r", int'(out_r), expR);
      checkOutput("hold_carry", int'(out_carry), expC);
      checkOutput("hold_valid", int'(out_valid), 1);
      checkOutput("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("released_valid", int'(out_valid), 0);
    checkOutput("released_in_ready", int'(in_ready), 1);
  endtask

  task automatic backToBack();
    int lowCnt = 0;
    bit got = 1'b0;
    bit got2 = 1'b0;
    @(negedge clk);
    waitReady("b2b_ready_wait");
    in_valid = 1'b1;
    in_op = 2'd1;
    in_a = 5'b00001;
    in_b = 5'd2;
    out_ready = 1'b1;
    @(negedge clk);
    in_op = 2'd2;
    in_a = 5'b11000;
    in_b = 5'd3;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) checkOutput("b2b_first_r", int'(out_r), 5'b00100);
      if (!busy) lowCnt++;
      if (in_ready) got = 1'b1;
      else @(negedge clk);
    end
    checkOutput("b2b_idle_seen", int'(got), 1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("b2b_second_busy", int'(busy), 1);
    for (int i = 0; i < 10 && !got2; i++) begin
      if (!busy) lowCnt++;
      if (out_valid) begin
        got2 = 1'b1;
        checkOutput("b2b_second_r", int'(out_r), 5'b00011);
        checkOutput("b2b_second_carry", int'(out_carry), 0);
      end else begin
        @(negedge clk);
      end
    end
    checkOutput("b2b_second_done", int'(got2), 1);
    checkOutput("b2b_busy_low_cycles", lowCnt, 1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic resetMidRun();
    @(negedge clk);
    waitReady("rst_ready_wait");
    in_valid = 1'b1;
    in_op = 2'd3;
    in_a = 5'b11111;
    in_b = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_r", int'(out_r), 0);
    checkOutput("rst_out_carry", int'(out_carry), 0);
    checkOutput("rst_out_zero", int'(out_zero), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int n, r, c;
    modelCalc(0, 5'b10011, 1, n, r, c);
    checkOutput("model_ror1_r", r, 5'b11001);
    checkOutput("model_ror1_c", c, 1);
    modelCalc(3, 5'b10011, 9, n, r, c);
    checkOutput("model_shl9_n", n, 5);
    checkOutput("model_shl9_r", r, 0);
    checkOutput("model_shl9_c", c, 1);
    modelCalc(1, 5'b10011, 1, n, r, c);
    checkOutput("model_rol1_r", r, 5'b00111);

    #12;
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_r", int'(out_r), 0);
    checkOutput("reset_out_zero", int'(out_zero), 1);
    checkOutput("reset_out_carry", int'(out_carry), 0);
    checkOutput("reset_busy", int'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    checkOn = 1'b1;

    applyStimulus(0, 5'b10011, 1, 5'b11001, 1, 2, 0);
    applyStimulus(0, 5'b10011, 7, 5'b11100, 1, 3, 0);
    applyStimulus(1, 5'b10011, 1, 5'b00111, 1, 2, 0);
    applyStimulus(3, 5'b10011, 9, 5'b00000, 1, 6, 0);
    applyStimulus(2, 5'b10110, 0, 5'b10110, 0, 1, 4);
    applyStimulus(2, 5'b11010, 3, 5'b00011, 0, 4, 2);
    applyStimulus(1, 5'b01000, 31, 5'b10000, 0, 2, 0);
    applyStimulus(0, 5'b00110, 5, 5'b00110, 0, 1, 1);
    backToBack();
    resetMidRun();
    applyStimulus(3, 5'b00111, 2, 5'b11100, 0, 3, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
